// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word on a
//   load/ready handshake and shifts it out MSB-first, one bit per clock,
//   with frame_start on the first bit and done on the last bit.
//
// Parameters
//   WIDTH        data word width (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   din          parallel word to transmit
//   load         source valid; accepted when load && ready at a clk edge
//   ready        idle, able to accept a word
//   sout         serial data, MSB first
//   sout_valid   sout carries a frame bit this cycle
//   frame_start  pulse on the first bit of a frame
//   done         pulse on the last bit of a frame
//
// Build option
//   SERIALIZER_PARITY_EN  appends an even-parity bit (XOR of din) after the
//                         LSB; done then marks the parity bit instead.

module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [FRAME-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ready_n;
  logic             valid_n;
  logic             fs_n;
  logic             done_n;
  logic [FRAME-1:0] load_word;

  // Parity rides in the shift register below the LSB, so the frame is just
  // one bit longer and the counter starts one higher.
`ifdef SERIALIZER_PARITY_EN
  assign load_word = {din, ^din};
`else
  assign load_word = din;
`endif

  // sout is the shift register MSB; clearing the register on frame exit
  // gives sout=0 while idle without a separate flop.
  assign sout = shreg[FRAME-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      ready       <= 1'b1;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      cnt         <= cnt_n;
      ready       <= ready_n;
      sout_valid  <= valid_n;
      frame_start <= fs_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    ready_n = ready;
    valid_n = sout_valid;
    fs_n    = 1'b0;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        ready_n = 1'b1;
        valid_n = 1'b0;
        shreg_n = '0;
        if (load) begin
          state_n = SHIFT;
          shreg_n = load_word;
          cnt_n   = CW'(FRAME - 1);
          ready_n = 1'b0;
          valid_n = 1'b1;
          fs_n    = 1'b1;
        end
      end

      SHIFT: begin
        if (cnt != '0) begin
          shreg_n = {shreg[FRAME-2:0], 1'b0};
          cnt_n   = cnt - CW'(1);
          done_n  = (cnt == CW'(1));
          ready_n = 1'b0;
          valid_n = 1'b1;
        end else begin
          state_n = IDLE;
          shreg_n = '0;
          cnt_n   = '0;
          ready_n = 1'b1;
          valid_n = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
        shreg_n = '0;
        cnt_n   = '0;
        ready_n = 1'b1;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int unsigned WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned FL = WIDTH + 1;
`else
  localparam int unsigned FL = WIDTH;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             done;
  logic             clk_en;

  int checks;
  int errors;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .load        (load),
    .ready       (ready),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, 32'(ready), 32'd1);
    check({tag, ".valid"}, 32'(sout_valid), 32'd0);
    check({tag, ".sout"}, 32'(sout), 32'd0);
    check({tag, ".fs"}, 32'(frame_start), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
  endtask

  // exp_bits: frame bits MSB-first, left-aligned in FL bits.
  // hold keeps load high throughout; din_mid is driven after acceptance;
  // load is pulsed for the edge following bit index pulse_k (-1 = never).
  task automatic send(input string tag, input logic [WIDTH-1:0] word,
                      input logic [FL-1:0] exp_bits, input bit hold,
                      input logic [WIDTH-1:0] din_mid, input int pulse_k);
    din  = word;
    load = 1'b1;
    for (int k = 0; k < int'(FL); k++) begin
      tick();
      check($sformatf("%s.b%0d.sout", tag, k), 32'(sout), 32'(exp_bits[FL-1-k]));
      check($sformatf("%s.b%0d.valid", tag, k), 32'(sout_valid), 32'd1);
      check($sformatf("%s.b%0d.ready", tag, k), 32'(ready), 32'd0);
      check($sformatf("%s.b%0d.fs", tag, k), 32'(frame_start), 32'(k == 0));
      check($sformatf("%s.b%0d.done", tag, k), 32'(done), 32'(k == int'(FL) - 1));
      din  = din_mid;
      load = hold ? 1'b1 : (k == pulse_k);
    end
    tick();
    check_idle({tag, ".end"});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    din    = '0;
    load   = 1'b0;

    // 1: async reset with clock stopped
    #2 rst_n = 1'b0;
    #1 check_idle("rst");
    clk_en = 1'b1;
    #12 rst_n = 1'b1;
    #1 check_idle("rst_rel");

    // 2: single word, load pulsed one cycle
`ifdef SERIALIZER_PARITY_EN
    send("a5", 8'hA5, 9'b1010_0101_0, 1'b0, 8'hA5, -1);
`else
    send("a5", 8'hA5, 8'b1010_0101, 1'b0, 8'hA5, -1);
`endif

    // 3: load held high, din changes mid-frame, exactly one idle cycle
`ifdef SERIALIZER_PARITY_EN
    send("3c", 8'h3C, 9'b0011_1100_0, 1'b1, 8'hC3, -1);
    send("c3", 8'hC3, 9'b1100_0011_0, 1'b0, 8'hC3, -1);
`else
    send("3c", 8'h3C, 8'b0011_1100, 1'b1, 8'hC3, -1);
    send("c3", 8'hC3, 8'b1100_0011, 1'b0, 8'hC3, -1);
`endif
    tick();
    check_idle("c3.gap");

    // 4: load pulse during bit 3 is ignored
`ifdef SERIALIZER_PARITY_EN
    send("ff", 8'hFF, 9'b1111_1111_0, 1'b0, 8'h00, 2);
`else
    send("ff", 8'hFF, 8'b1111_1111, 1'b0, 8'h00, 2);
`endif
    tick();
    check_idle("ff.nofr");
    tick();
    check_idle("ff.nofr2");

    // 5: reset mid-frame after bit 4, then clean frame
    din  = 8'h81;
    load = 1'b1;
    tick();
    check("81.b0", 32'(sout), 32'd1);
    load = 1'b0;
    tick();
    tick();
    tick();
    check("81.b3", 32'(sout), 32'd0);
    check("81.b3.valid", 32'(sout_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle("81.rst");
    tick();
    check_idle("81.rst_hold");
    #2 rst_n = 1'b1;
    tick();
    check_idle("81.rel");
`ifdef SERIALIZER_PARITY_EN
    send("01", 8'h01, 9'b0000_0001_1, 1'b0, 8'h01, -1);
`else
    send("01", 8'h01, 8'b0000_0001, 1'b0, 8'h01, -1);
`endif

    // 6: parity bit
`ifdef SERIALIZER_PARITY_EN
    send("p07", 8'h07, 9'b0000_0111_1, 1'b0, 8'h07, -1);
    send("p03", 8'h03, 9'b0000_0011_0, 1'b0, 8'h03, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
